// File: rtl/frame_reorder_pkg.sv
// frame_reorder_pkg: modes, frame lengths and mixed-radix digit
// constants shared by the frame reorder buffer and its digit counter.
package frame_reorder_pkg;

    typedef enum logic [1:0] {M_ID, M_15, M_45, M_9} mode_t;
    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN} state_t;

    localparam int N_15 = 15;
    localparam int N_45 = 45;
    localparam int N_9  = 9;
    localparam int N_ID = 64;

    // Per-mode digit maxima (radix-1), weights, and the
    // wrap spans s = w*(radix-1) subtracted when a digit rolls over.
    typedef struct packed {
        logic [5:0] m0;
        logic [5:0] m1;
        logic [5:0] m2;
        logic [5:0] w0;
        logic [5:0] w1;
        logic [5:0] w2;
        logic [5:0] s0;
        logic [5:0] s1;
    } mr_cfg_t;

    function automatic logic sel_legal(input logic [2:0] s);
        return s <= 3'd4;
    endfunction

    function automatic mode_t sel_to_mode(input logic [2:0] s);
        mode_t m;
        case (s)
            3'd2:    m = M_15;
            3'd3:    m = M_45;
            3'd4:    m = M_9;
            default: m = M_ID;
        endcase
        return m;
    endfunction

    function automatic logic [6:0] mode_len(input mode_t m);
        logic [6:0] n;
        case (m)
            M_15:    n = 7'(N_15);
            M_45:    n = 7'(N_45);
            M_9:     n = 7'(N_9);
            default: n = 7'(N_ID);
        endcase
        return n;
    endfunction

    function automatic mr_cfg_t mode_cfg(input mode_t m);
        mr_cfg_t c;
        c = '0;
        case (m)
            M_15: begin
                c.m0 = 6'd4; c.w0 = 6'd3; c.s0 = 6'd12;
                c.m1 = 6'd2; c.w1 = 6'd1; c.s1 = 6'd2;
            end
            M_45: begin
                c.m0 = 6'd2; c.w0 = 6'd15; c.s0 = 6'd30;
                c.m1 = 6'd2; c.w1 = 6'd5;  c.s1 = 6'd10;
                c.m2 = 6'd4; c.w2 = 6'd1;
            end
            M_9: begin
                c.m0 = 6'd2; c.w0 = 6'd3; c.s0 = 6'd6;
                c.m1 = 6'd2; c.w1 = 6'd1; c.s1 = 6'd2;
            end
            default: begin
                c.m0 = 6'd63; c.w0 = 6'd1; c.s0 = 6'd63;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mr_digit_cnt.sv
// mr_digit_cnt: three-digit mixed-radix counter producing perm(j).
// Ports: clk, rst (sync, high), clear, advance, mode -> raddr, last.
module mr_digit_cnt
    import frame_reorder_pkg::*;
#(
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          advance,
    input  mode_t         mode,
    output logic [AW-1:0] raddr,
    output logic          last
);

    mr_cfg_t       w_cfg;
    logic [5:0]    r_d0;
    logic [5:0]    r_d1;
    logic [5:0]    r_d2;
    logic [AW-1:0] r_addr;

    assign w_cfg = mode_cfg(mode);
    assign raddr = r_addr;
    assign last  = (r_d0 == w_cfg.m0) &&
                   (r_d1 == w_cfg.m1) &&
                   (r_d2 == w_cfg.m2);

    // The address tracks sum(d_i*w_i); a wrapping digit
    // subtracts its span before the carry adds the next weight.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_d0   <= '0;
            r_d1   <= '0;
            r_d2   <= '0;
            r_addr <= '0;
        end else if (advance) begin
            if (r_d0 != w_cfg.m0) begin
                r_d0   <= r_d0 + 6'd1;
                r_addr <= r_addr + AW'(w_cfg.w0);
            end else begin
                r_d0 <= '0;
                if (r_d1 != w_cfg.m1) begin
                    r_d1   <= r_d1 + 6'd1;
                    r_addr <= r_addr - AW'(w_cfg.s0)
                              + AW'(w_cfg.w1);
                end else begin
                    r_d1 <= '0;
                    if (r_d2 != w_cfg.m2) begin
                        r_d2   <= r_d2 + 6'd1;
                        r_addr <= r_addr - AW'(w_cfg.s0)
                                  - AW'(w_cfg.s1)
                                  + AW'(w_cfg.w2);
                    end else begin
                        r_d2   <= '0;
                        r_addr <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/frame_reorder.sv
// frame_reorder: stores a frame in natural order, emits input[perm(j)].
// Ports: clk, rst, sel, in_* / out_* handshakes, sel_err sticky flag.
// Option FRAME_REORDER_PINGPONG_EN: two banks, fill overlaps drain.
module frame_reorder
    import frame_reorder_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    sel,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          sel_err
);

`ifdef FRAME_REORDER_PINGPONG_EN
    localparam int MAW = AW + 1;
`else
    localparam int MAW = AW;
`endif

    state_t        r_state;
    logic [AW-1:0] r_wcnt;
    mode_t         r_wmode;
    mode_t         r_rmode;
    logic          r_sel_err;
    logic          r_rd_act;
    logic          r_rd_vld;
    logic          r_rd_last;
    logic [DW-1:0] r_rdata;
    logic [DW-1:0] r_q_data [2];
    logic [1:0]    r_q_last;
    logic [1:0]    r_q_cnt;
    logic [DW-1:0] r_mem [2**MAW];

    logic           w_acc;
    logic           w_wr;
    logic           w_fill_done;
    logic           w_rd_start;
    logic           w_issue;
    logic           w_pop;
    logic           w_cnt_last;
    logic [AW-1:0]  w_waddr;
    logic [AW-1:0]  w_raddr;
    logic [MAW-1:0] w_widx;
    logic [MAW-1:0] w_ridx;
    logic [6:0]     w_len;
    logic [2:0]     w_occ;
    mode_t          w_fmode;
    state_t         w_nxt_fill;

    assign in_ready  = ~rst & (r_state != S_DRAIN);
    assign out_valid = (r_q_cnt != 2'd0);
    assign out_data  = r_q_data[0];
    assign out_last  = r_q_last[0] & out_valid;
    assign sel_err   = r_sel_err;

    assign w_acc   = in_valid & in_ready;
    assign w_fmode = (r_state == S_IDLE) ? sel_to_mode(sel)
                                         : r_wmode;
    assign w_waddr = (r_state == S_IDLE) ? '0 : r_wcnt;
    assign w_len   = mode_len(w_fmode);
    assign w_wr    = w_acc &
                     ((r_state != S_IDLE) | sel_legal(sel));
    assign w_fill_done = w_wr &
                     (int'(w_waddr) == int'(w_len) - 1);

    // Reads are issued only while the skid plus the read in
    // flight can still absorb the result after this cycle's pop.
    assign w_pop   = out_valid & out_ready;
    assign w_occ   = {1'b0, r_q_cnt} + {2'b0, r_rd_vld}
                     - {2'b0, w_pop};
    assign w_issue = r_rd_act & (w_occ < 3'd2);

`ifdef FRAME_REORDER_PINGPONG_EN
    logic r_wbank;
    logic r_rbank;
    logic w_rd_busy;

    // A bank is free once its final read has been issued,
    // which lets the next frame start without a bubble.
    assign w_rd_busy  = r_rd_act & ~(w_issue & w_cnt_last);
    assign w_rd_start = ~w_rd_busy &
                        (w_fill_done | (r_state == S_DRAIN));
    assign w_nxt_fill = w_rd_start ? S_IDLE : S_DRAIN;
    assign w_widx     = {r_wbank, w_waddr};
    assign w_ridx     = {r_rbank, w_raddr};
`else
    logic w_out_fin;

    assign w_out_fin  = w_pop & out_last;
    assign w_rd_start = w_fill_done;
    assign w_nxt_fill = S_DRAIN;
    assign w_widx     = w_waddr;
    assign w_ridx     = w_raddr;
`endif

    mr_digit_cnt #(
        .AW(AW)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_rd_start),
        .advance (w_issue),
        .mode    (r_rmode),
        .raddr   (w_raddr),
        .last    (w_cnt_last)
    );

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[w_widx] <= in_data;
        end
        if (w_issue) begin
            r_rdata <= r_mem[w_ridx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_wcnt    <= '0;
            r_wmode   <= M_ID;
            r_rmode   <= M_ID;
            r_sel_err <= 1'b0;
            r_rd_act  <= 1'b0;
`ifdef FRAME_REORDER_PINGPONG_EN
            r_wbank   <= 1'b0;
            r_rbank   <= 1'b0;
`endif
        end else begin
            if (w_rd_start) begin
                r_rd_act <= 1'b1;
                r_rmode  <= w_fmode;
`ifdef FRAME_REORDER_PINGPONG_EN
                r_rbank  <= r_wbank;
                r_wbank  <= ~r_wbank;
`endif
            end else if (w_issue & w_cnt_last) begin
                r_rd_act <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        if (!sel_legal(sel)) begin
                            r_sel_err <= 1'b1;
                        end else begin
                            r_wmode <= sel_to_mode(sel);
                            if (w_fill_done) begin
                                r_state <= w_nxt_fill;
                            end else begin
                                r_wcnt  <= AW'(1);
                                r_state <= S_FILL;
                            end
                        end
                    end
                end
                S_FILL: begin
                    if (w_wr) begin
                        if (w_fill_done) begin
                            r_wcnt  <= '0;
                            r_state <= w_nxt_fill;
                        end else begin
                            r_wcnt <= r_wcnt + AW'(1);
                        end
                    end
                end
                S_DRAIN: begin
`ifdef FRAME_REORDER_PINGPONG_EN
                    if (w_rd_start) begin
                        r_state <= S_IDLE;
                    end
`else
                    if (w_out_fin) begin
                        r_state <= S_IDLE;
                    end
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Read pipeline and 2-entry output skid; entry 0 is the head.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_vld  <= 1'b0;
            r_rd_last <= 1'b0;
            r_q_cnt   <= 2'd0;
            r_q_last  <= 2'b00;
            r_q_data[0] <= '0;
            r_q_data[1] <= '0;
        end else begin
            r_rd_vld <= w_issue;
            if (w_issue) begin
                r_rd_last <= w_cnt_last;
            end
            case ({r_rd_vld, w_pop})
                2'b10: begin
                    if (r_q_cnt == 2'd0) begin
                        r_q_data[0] <= r_rdata;
                        r_q_last[0] <= r_rd_last;
                    end else begin
                        r_q_data[1] <= r_rdata;
                        r_q_last[1] <= r_rd_last;
                    end
                    r_q_cnt <= r_q_cnt + 2'd1;
                end
                2'b01: begin
                    r_q_data[0] <= r_q_data[1];
                    r_q_last[0] <= r_q_last[1];
                    r_q_cnt     <= r_q_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_q_cnt == 2'd1) begin
                        r_q_data[0] <= r_rdata;
                        r_q_last[0] <= r_rd_last;
                    end else begin
                        r_q_data[0] <= r_q_data[1];
                        r_q_last[0] <= r_q_last[1];
                        r_q_data[1] <= r_rdata;
                        r_q_last[1] <= r_rd_last;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
